regfile_dump_load: RTL and testbench
====================================

REGFILE_DUMP_LOAD -- requirements
Module: regfile_dump_load

Interface
REQ-001 The block SHALL have parameter FIRST_REG, default 1, the first register index visited.
REQ-002 The block SHALL have parameter LAST_REG, default 31, the last register index visited; FIRST_REG <= LAST_REG <= 31.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request a sequence, sampled in IDLE only.
REQ-006 mode  input  1  0 = dump (read registers out), 1 = load (write registers in); sampled with start.
REQ-007 abort  input  1  terminate the current sequence.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse on normal completion.
REQ-010 rf_read_addr  output  5  register file read-port address.
REQ-011 rf_read_data  input  32  register file read data, combinational from rf_read_addr.
REQ-012 rf_write_addr / rf_write_data / rf_reg_write  output  5/32/1  register file write port.
REQ-013 out_valid, out_data[31:0], out_index[4:0], out_last  output  dump stream; out_ready  input  1.
REQ-014 in_valid, in_data[31:0]  input  load stream; in_ready  output  1.

Function
REQ-015 The FSM SHALL have states IDLE, DUMP_RD, DUMP_OUT, LOAD, DONE, with an index counter idx[4:0].
REQ-016 In IDLE with start=1 and abort=0: idx<=FIRST_REG; next state DUMP_RD (mode=0) or LOAD (mode=1).
REQ-017 In DUMP_RD: rf_read_addr=idx; at the edge, out_data<=rf_read_data, out_index<=idx, out_last<=(idx==LAST_REG); next state DUMP_OUT.
REQ-018 In DUMP_OUT: out_valid=1; out_data, out_index and out_last SHALL be held stable until out_valid&out_ready.
REQ-019 On a DUMP_OUT handshake: if idx==LAST_REG, go to DONE; otherwise idx<=idx+1 and go to DUMP_RD. Throughput is one word per two cycles with out_ready held high.
REQ-020 In LOAD: in_ready=1; each in_valid&in_ready beat SHALL, in the next cycle, drive rf_reg_write=1 for exactly one cycle, with rf_write_addr=idx and rf_write_data=in_data.
REQ-021 On a LOAD beat with idx==LAST_REG, the next state is DONE; otherwise idx<=idx+1.
REQ-022 In DONE: done=1 for one cycle; next state IDLE.
REQ-023 abort=1 in any non-IDLE state SHALL force IDLE at the next edge, with no done pulse. out_valid and in_ready drop in that cycle. A write already registered for an accepted beat still completes.
REQ-024 start is ignored while busy. In IDLE, start and abort together: abort wins and the block stays IDLE.
REQ-025 rf_read_addr SHALL be 0 outside DUMP_RD. rf_reg_write SHALL be 0 except as in REQ-020.

Reset
REQ-026 reset_n low SHALL immediately set: state IDLE, idx=FIRST_REG, and all outputs 0 (busy, done, out_valid, out_data, out_index, out_last, in_ready, rf_reg_write, rf_write_addr, rf_write_data, rf_read_addr).
REQ-027 Reset during a sequence abandons it. Any pending write SHALL NOT be issued.

Structure
REQ-028 The state enum and the MODE_DUMP/MODE_LOAD constants SHALL live in the shared package regfile_pkg.
REQ-029 The block SHALL be a single module with no sub-modules; the idx counter and FSM are inline.

Verification
REQ-030 Register file freshly reset, dump with out_ready=1 -> 31 words for indices 1..31, index 29 = 0x000007FC, all others 0, out_last only on index 31, one done pulse.
REQ-031 Dump with out_ready low for 5 cycles on index 3 -> out_valid held, out_data/out_index stable for those 5 cycles, no word skipped or duplicated.
REQ-032 Load of 31 words 0x100+i (in_valid toggling), then dump -> register i reads 0x100+i for i=1..31.
REQ-033 abort after 10 load beats -> registers 1..10 written, register 11 unchanged, no done, busy low the next cycle.
REQ-034 reset_n low mid-dump at index 7 -> all outputs 0 immediately; after release, start dumps again from index 1.
REQ-035 start pulsed during a load -> ignored; the sequence completes normally with exactly 31 writes.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file dump/load sequencer: FSM states,
// stream direction constants and register-file port widths.
package regfile_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DUMP_RD  = 3'd1,
        DUMP_OUT = 3'd2,
        LOAD     = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic MODE_DUMP = 1'b0;
    localparam logic MODE_LOAD = 1'b1;

    localparam int unsigned REG_IDX_W  = 5;
    localparam int unsigned REG_DATA_W = 32;

endpackage

// File: rtl/regfile_dump_load.sv
// Walks register indices FIRST_REG..LAST_REG, either streaming register contents
// out (dump) or writing an incoming word stream into the register file (load).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; all outputs quiet
// DUMP_RD  | read port addressed by idx; word captured into out_* at edge
// DUMP_OUT | out_valid high, captured word held until out_ready
// LOAD     | in_ready high; each beat queues one register write
// DONE     | one-cycle done pulse, then back to IDLE
module regfile_dump_load
    import regfile_pkg::*;
#(
    parameter int unsigned FIRST_REG = 1,
    parameter int unsigned LAST_REG  = 31
)
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [REG_IDX_W-1:0]  rf_read_addr,
    input  logic [REG_DATA_W-1:0] rf_read_data,
    output logic [REG_IDX_W-1:0]  rf_write_addr,
    output logic [REG_DATA_W-1:0] rf_write_data,
    output logic                  rf_reg_write,
    output logic                  out_valid,
    output logic [REG_DATA_W-1:0] out_data,
    output logic [REG_IDX_W-1:0]  out_index,
    output logic                  out_last,
    input  logic                  out_ready,
    input  logic                  in_valid,
    input  logic [REG_DATA_W-1:0] in_data,
    output logic                  in_ready
);

    localparam logic [REG_IDX_W-1:0] FIRST_IDX = REG_IDX_W'(FIRST_REG);
    localparam logic [REG_IDX_W-1:0] LAST_IDX  = REG_IDX_W'(LAST_REG);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [REG_IDX_W-1:0]    r_idx;
    logic                    w_idx_last;
    logic                    w_launch;
    logic                    w_out_hs;
    logic                    w_in_beat;

    logic [REG_DATA_W-1:0]   r_out_data;
    logic [REG_IDX_W-1:0]    r_out_index;
    logic                    r_out_last;

    logic                    r_wr_en;
    logic [REG_IDX_W-1:0]    r_wr_addr;
    logic [REG_DATA_W-1:0]   r_wr_data;

    assign w_idx_last = (r_idx == LAST_IDX);
    assign w_launch   = (r_state == IDLE) && start && !abort;
    assign w_out_hs   = out_valid && out_ready;
    assign w_in_beat  = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // abort gates the handshakes, so no beat or word is accepted in its cycle
    always_comb begin
        w_state_nxt  = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        out_valid    = 1'b0;
        in_ready     = 1'b0;
        rf_read_addr = '0;

        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = (mode == MODE_LOAD) ? LOAD : DUMP_RD;
                end
            end

            DUMP_RD: begin
                busy         = 1'b1;
                rf_read_addr = r_idx;
                w_state_nxt  = abort ? IDLE : DUMP_OUT;
            end

            DUMP_OUT: begin
                busy      = 1'b1;
                out_valid = !abort;
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (out_ready) begin
                    w_state_nxt = w_idx_last ? DONE : DUMP_RD;
                end
            end

            LOAD: begin
                busy     = 1'b1;
                in_ready = !abort;
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (in_valid && w_idx_last) begin
                    w_state_nxt = DONE;
                end
            end

            DONE: begin
                busy        = 1'b1;
                done        = !abort;
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx <= FIRST_IDX;
        end else if (w_launch) begin
            r_idx <= FIRST_IDX;
        end else if ((w_out_hs || w_in_beat) && !w_idx_last) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
        end else if (r_state == DUMP_RD) begin
            r_out_data  <= rf_read_data;
            r_out_index <= r_idx;
            r_out_last  <= w_idx_last;
        end
    end

    // Load writes are issued one cycle after the beat; an abort in that cycle
    // does not cancel the write, only reset does.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_in_beat;
            if (w_in_beat) begin
                r_wr_addr <= r_idx;
                r_wr_data <= in_data;
            end
        end
    end

    assign out_data      = r_out_data;
    assign out_index     = r_out_index;
    assign out_last      = r_out_last;
    assign rf_reg_write  = r_wr_en;
    assign rf_write_addr = r_wr_addr;
    assign rf_write_data = r_wr_data;

endmodule

// File: tb/tb_regfile_dump_load.sv
// Bench for regfile_dump_load: behavioural register file, table of sequences
// with randomized handshakes, and hand-written hold/abort/reset cases.
module tb_regfile_dump_load;

    localparam int FIRST = 1;
    localparam int LAST  = 31;
    localparam int NREG  = LAST - FIRST + 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;

    logic        busy, done, rf_reg_write, out_valid, out_last, in_ready;
    logic [4:0]  rf_read_addr, rf_write_addr, out_index;
    logic [31:0] rf_read_data, rf_write_data, out_data;

    regfile_dump_load #(.FIRST_REG(FIRST), .LAST_REG(LAST)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .abort(abort),
        .busy(busy), .done(done),
        .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .rf_reg_write(rf_reg_write),
        .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
        .out_last(out_last), .out_ready(out_ready),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return (i == 29) ? 32'h0000_07FC : 32'h0;
    endfunction

    // behavioural register file, cleared to its power-up contents by rf_clear
    logic        rf_clear = 1'b1;
    logic [31:0] rf [32];
    assign rf_read_data = rf[rf_read_addr];

    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
        end else if (rf_reg_write) begin
            rf[rf_write_addr] <= rf_write_data;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model: beat k of a load lands in register FIRST+k
    logic [31:0] model_rf [32];
    logic [37:0] dump_q[$];
    logic [36:0] wr_q[$];
    logic [36:0] exp_wr_q[$];
    int          beats = 0;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready)
                dump_q.push_back({out_last, out_index, out_data});
            if (in_valid && in_ready && beats < NREG) begin
                exp_wr_q.push_back({5'(FIRST + beats), in_data});
                model_rf[FIRST + beats] = in_data;
                beats++;
            end
            if (rf_reg_write)
                wr_q.push_back({rf_write_addr, rf_write_data});
            if (done)
                done_cnt++;
            if (!busy)
                check("idle_quiet", 64'({rf_read_addr, out_valid, in_ready, done}), 64'h0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit mode;
        int stall_pct;
        int abort_after;
        int hold_idx;
        bit start_noise;
        bit inc_data;
        int exp_words;
        int exp_done;
    } vec_t;

    vec_t vecs [8];

    task automatic run_seq(input vec_t v);
        int cyc;
        int held;
        int cyc_abort;
        bit aborted;
        int cnt;
        dump_q.delete();
        wr_q.delete();
        exp_wr_q.delete();
        beats = 0;
        done_cnt = 0;
        held = 0;
        aborted = 0;
        cyc_abort = 0;
        cyc = 0;

        mode  = v.mode;
        start = 1'b1;
        step();
        start = 1'b0;

        while (busy && cyc < 600) begin
            out_ready = (int'($urandom_range(99)) >= v.stall_pct);
            in_valid  = (int'($urandom_range(99)) >= v.stall_pct);
            in_data   = v.inc_data ? 32'(32'h100 + FIRST + beats) : $urandom;
            if (v.start_noise) begin
                start = 1'($urandom_range(1));
                mode  = 1'($urandom_range(1));
            end
            if (v.hold_idx >= 0 && held < 5 &&
                (held > 0 || (out_valid && int'(out_index) == v.hold_idx))) begin
                out_ready = 1'b0;
                check("hold_valid", 64'(out_valid), 64'h1);
                check("hold_index", 64'(out_index), 64'(v.hold_idx));
                check("hold_data", 64'(out_data), 64'(model_rf[v.hold_idx]));
                held++;
            end
            cnt = (v.mode == 1'b1) ? beats : dump_q.size();
            if (v.abort_after >= 0 && !aborted && cnt == v.abort_after) begin
                abort     = 1'b1;
                aborted   = 1'b1;
                cyc_abort = cyc;
            end else begin
                abort = 1'b0;
            end
            step();
            cyc++;
        end
        abort     = 1'b0;
        start     = 1'b0;
        mode      = v.mode;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        step();

        check("seq_ends_idle", 64'(busy), 64'h0);
        check("done_count", 64'(done_cnt), 64'(v.exp_done));
        if (aborted)
            check("abort_latency", 64'(cyc - cyc_abort), 64'h1);
        if (v.hold_idx >= 0)
            check("hold_cycles", 64'(held), 64'd5);
        if (v.stall_pct == 0 && v.abort_after < 0 && v.hold_idx < 0 && !v.start_noise)
            check("seq_cycles", 64'(cyc), v.mode ? 64'd32 : 64'd63);

        if (v.mode == 1'b0) begin
            check("dump_words", 64'(dump_q.size()), 64'(v.exp_words));
            for (int k = 0; k < dump_q.size() && k < NREG; k++)
                check("dump_word", 64'(dump_q[k]),
                      64'({(FIRST + k) == LAST, 5'(FIRST + k), model_rf[FIRST + k]}));
        end else begin
            int diffs;
            check("write_count", 64'(wr_q.size()), 64'(v.exp_words));
            for (int k = 0; k < wr_q.size() && k < exp_wr_q.size(); k++)
                check("write_beat", 64'(wr_q[k]), 64'(exp_wr_q[k]));
            diffs = 0;
            for (int i = 0; i < 32; i++)
                if (rf[i] !== model_rf[i]) diffs++;
            check("rf_contents", 64'(diffs), 64'h0);
        end
    endtask

    initial begin
        // mode, stall%, abort_after, hold_idx, start_noise, inc_data, words, done
        vecs[0] = '{1'b0,  0, -1, -1, 1'b0, 1'b0, 31, 1};
        vecs[1] = '{1'b0,  0, -1,  3, 1'b0, 1'b0, 31, 1};
        vecs[2] = '{1'b1, 50, -1, -1, 1'b0, 1'b1, 31, 1};
        vecs[3] = '{1'b0, 30, -1, -1, 1'b0, 1'b0, 31, 1};
        vecs[4] = '{1'b1,  0, 10, -1, 1'b0, 1'b0, 10, 0};
        vecs[5] = '{1'b1, 40, -1, -1, 1'b1, 1'b0, 31, 1};
        vecs[6] = '{1'b0, 50, 17, -1, 1'b0, 1'b0, 17, 0};
        vecs[7] = '{1'b1,  0, -1, -1, 1'b0, 1'b0, 31, 1};

        for (int i = 0; i < 32; i++) model_rf[i] = init_val(i);

        #1;
        check("rst0_data", 64'({out_data, rf_write_data}), 64'h0);
        check("rst0_ctrl", 64'({busy, done, out_valid, out_index, out_last, in_ready,
                                rf_reg_write, rf_write_addr, rf_read_addr}), 64'h0);
        step();
        step();
        reset_n  = 1'b1;
        rf_clear = 1'b0;
        step();
        check("post_rst_busy", 64'(busy), 64'h0);

        for (int i = 0; i < 8; i++) begin
            run_seq(vecs[i]);
            if (i == 0 && dump_q.size() > 28)
                check("reg29_dump", 64'(dump_q[28][31:0]), 64'h7FC);
            if (i == 3) begin
                int errs;
                errs = 0;
                for (int k = 0; k < dump_q.size(); k++)
                    if (dump_q[k][31:0] !== 32'(32'h100 + dump_q[k][36:32])) errs++;
                check("load_pattern_readback", 64'(errs), 64'h0);
            end
            if (i == 4) begin
                check("reg11_kept", 64'(rf[11]), 64'h10B);
                check("reg10_new", 64'(rf[10]), 64'(model_rf[10]));
            end
        end

        // reset while the word for index 7 is on the dump stream
        mode      = 1'b0;
        start     = 1'b1;
        step();
        start     = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (out_valid && out_index == 5'd7) break;
            step();
        end
        out_ready = 1'b0;
        check("reached_idx7", 64'({out_valid, out_index}), 64'({1'b1, 5'd7}));
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_data", 64'({out_data, rf_write_data}), 64'h0);
        check("rst_ctrl", 64'({busy, done, out_valid, out_index, out_last, in_ready,
                               rf_reg_write, rf_write_addr, rf_read_addr}), 64'h0);
        step();
        step();
        reset_n = 1'b1;
        step();
        run_seq(vecs[0]);
        run_seq(vecs[3]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

endmodule
